soc_gpio_bank: RTL and testbench

Parametrised GPIO register bank that replaces the fixed 8-bit write-only LED register of the SoC top with a general I/O port. It has width-configurable output, output-enable and synchronised input registers, plus atomic set/clear/toggle aliases and per-pin edge-detect interrupts. It sits on the PicoRV32 native memory bus behind the top-level address decoder, which supplies a window select. The block runs with a one-cycle registered ready, like the other I/O slaves.

---
 rtl/soc_gpio_pkg.sv | 29 ++
 rtl/gpio_sync.sv | 32 +++
 rtl/soc_gpio_bank.sv | 186 ++++++++++++++++++
 tb/tb_soc_gpio_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_gpio_pkg.sv
// GPIO bank shared definitions: register offsets, access FSM encoding, strobe helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package soc_gpio_pkg;

    // Word offsets within the 16-word GPIO window
    localparam logic [3:0] GPIO_OUT     = 4'd0;
    localparam logic [3:0] GPIO_OE      = 4'd1;
    localparam logic [3:0] GPIO_IN      = 4'd2;
    localparam logic [3:0] GPIO_SET     = 4'd3;
    localparam logic [3:0] GPIO_CLR     = 4'd4;
    localparam logic [3:0] GPIO_TGL     = 4'd5;
    localparam logic [3:0] GPIO_IRQ_EN  = 4'd6;
    localparam logic [3:0] GPIO_RISE_EN = 4'd7;
    localparam logic [3:0] GPIO_FALL_EN = 4'd8;
    localparam logic [3:0] GPIO_STATUS  = 4'd9;

    // Bus access FSM: IDLE accepts a select, ACK holds ready for one cycle
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } gpio_state_t;

    // Expand byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for asynchronous pin inputs.
// Latency: STAGES clock edges from pin to q.
// Backpressure: none; free-running.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift pins through the synchroniser chain; all stages clear on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/soc_gpio_bank.sv
// GPIO register bank on the PicoRV32 native bus: OUT/OE/IN, set/clr/tgl aliases, edge interrupts.
// Latency: one cycle; select sampled at edge k, ready and rdata valid for cycle k..k+1.
// Backpressure: none; every select completes with a single ready pulse, selects during ACK are ignored.
module soc_gpio_bank
    import soc_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_OE    = '1,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sel,
    input  logic [3:0]       addr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    gpio_state_t      state_q;
    gpio_state_t      state_nxt;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] pin_p_q;
    logic [31:0]      rdata_q;

    logic [31:0]      lane_mask;
    logic [31:0]      wdata_masked;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] wr_dat;
    logic             unused_hi_bits;

    logic             take;
    logic             wr;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] rd_pins;
    logic [31:0]      rd_val;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (gpio_i),
        .q      (pin_s)
    );

    // Only bytes with their strobe set carry data; bits above WIDTH are dropped
    assign lane_mask      = strb_mask(wstrb);
    assign wdata_masked   = wdata & lane_mask;
    assign wr_mask        = lane_mask[WIDTH-1:0];
    assign wr_dat         = wdata_masked[WIDTH-1:0];
    assign unused_hi_bits = ^{lane_mask, wdata_masked};

    // A select is only accepted in IDLE; zero strobes mean a read
    assign take = (state_q == ST_IDLE) && sel;
    assign wr   = take && (wstrb != 4'b0000);

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next state: IDLE -> ACK on select, ACK always returns to IDLE
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (sel) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: ready is decoded from registered state, rdata is the latched read value
    always_comb begin
        ready = (state_q == ST_ACK);
        rdata = rdata_q;
    end

    // Next OUT value from plain write or the atomic set/clear/toggle aliases
    always_comb begin
        out_nxt = out_q;
        if (wr) begin
            case (addr)
                GPIO_OUT: out_nxt = (out_q & ~wr_mask) | wr_dat;
                GPIO_SET: out_nxt = out_q | wr_dat;
                GPIO_CLR: out_nxt = out_q & ~wr_dat;
                GPIO_TGL: out_nxt = out_q ^ wr_dat;
                default:  out_nxt = out_q;
            endcase
        end
    end

    // Pin drive registers: OUT and OE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q <= RESET_OUT;
            oe_q  <= RESET_OE;
        end else begin
            out_q <= out_nxt;
            if (wr && addr == GPIO_OE) begin
                oe_q <= (oe_q & ~wr_mask) | wr_dat;
            end
        end
    end

    // Interrupt and edge enable registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr) begin
            if (addr == GPIO_IRQ_EN)  irq_en_q  <= (irq_en_q  & ~wr_mask) | wr_dat;
            if (addr == GPIO_RISE_EN) rise_en_q <= (rise_en_q & ~wr_mask) | wr_dat;
            if (addr == GPIO_FALL_EN) fall_en_q <= (fall_en_q & ~wr_mask) | wr_dat;
        end
    end

    // Enabled edges on the synchronised pins; a same-cycle event beats a W1C
    assign edge_ev = (pin_s & ~pin_p_q & rise_en_q) | (~pin_s & pin_p_q & fall_en_q);
    assign w1c     = (wr && addr == GPIO_STATUS) ? wr_dat : '0;

    // Previous-cycle pin sample and sticky edge status
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pin_p_q  <= '0;
            status_q <= '0;
        end else begin
            pin_p_q  <= pin_s;
            status_q <= (status_q & ~w1c) | edge_ev;
        end
    end

    // Read mux over pre-edge register values, zero-extended to the bus width
    always_comb begin
        rd_pins = '0;
        case (addr)
            GPIO_OUT:     rd_pins = out_q;
            GPIO_OE:      rd_pins = oe_q;
            GPIO_IN:      rd_pins = pin_s;
            GPIO_IRQ_EN:  rd_pins = irq_en_q;
            GPIO_RISE_EN: rd_pins = rise_en_q;
            GPIO_FALL_EN: rd_pins = fall_en_q;
            GPIO_STATUS:  rd_pins = status_q;
            default:      rd_pins = '0;
        endcase
        rd_val              = '0;
        rd_val[WIDTH-1:0]   = rd_pins;
    end

    // Read data is held only for the ACK cycle and is zero otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (take && !wr) begin
            rdata_q <= rd_val;
        end else begin
            rdata_q <= '0;
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = oe_q;
    assign irq     = |(status_q & irq_en_q);

endmodule

// File: tb/tb_soc_gpio_bank.sv
module tb_soc_gpio_bank;
    import soc_gpio_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic        sel12;
    logic [3:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe;
    logic        irq;

    logic [31:0] rdata12;
    logic        ready12;
    logic [11:0] gpio_i12;
    logic [11:0] gpio_o12;
    logic [11:0] gpio_oe12;
    logic        irq12;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    soc_gpio_bank #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .resetn  (resetn),
        .sel     (sel),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    soc_gpio_bank #(.WIDTH(12)) u_dut12 (
        .clk     (clk),
        .resetn  (resetn),
        .sel     (sel12),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .rdata   (rdata12),
        .ready   (ready12),
        .gpio_i  (gpio_i12),
        .gpio_o  (gpio_o12),
        .gpio_oe (gpio_oe12),
        .irq     (irq12)
    );

    // One bus transaction; reads push their expected value and pop it when ready is seen
    task automatic bus(input bit w12, input logic [3:0] a, input logic [3:0] ws,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
        logic        rdy;
        logic [31:0] got;
        logic [31:0] want;
        @(negedge clk);
        addr  = a;
        wstrb = ws;
        wdata = wd;
        sel   = !w12;
        sel12 = w12;
        if (ws == 4'b0000) exp_q.push_back(exp_rd);
        @(posedge clk); #1;
        sel   = 1'b0;
        sel12 = 1'b0;
        rdy = w12 ? ready12 : ready;
        got = w12 ? rdata12 : rdata;
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL bus_ready_high addr=%0d got=%b want=1", a, rdy);
        else n_pass++;
        if (ws == 4'b0000) begin
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL bus_rdata addr=%0d got=%h want=%h", a, got, want);
            else n_pass++;
        end
        @(posedge clk); #1;
        rdy = w12 ? ready12 : ready;
        got = w12 ? rdata12 : rdata;
        n_checks++;
        if (rdy !== 1'b0 || got !== 32'h0)
            $display("FAIL bus_ready_low addr=%0d got=%b/%h want=0/0", a, rdy, got);
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0; sel = 1'b0; sel12 = 1'b0;
        addr = '0; wstrb = '0; wdata = '0; gpio_i = '0; gpio_i12 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0 || rdata !== 32'h0 || gpio_o !== 8'h00 || gpio_oe !== 8'hFF || irq !== 1'b0)
            $display("FAIL reset_outputs got rdy=%b rd=%h o=%h oe=%h irq=%b want 0/0/00/ff/0",
                     ready, rdata, gpio_o, gpio_oe, irq);
        else n_pass++;
        n_checks++;
        if (gpio_oe12 !== 12'hFFF || gpio_o12 !== 12'h000)
            $display("FAIL reset_w12 got o=%h oe=%h want 000/fff", gpio_o12, gpio_oe12);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        bus(1'b0, GPIO_OUT,    4'b0000, '0, 32'h0000_0000);
        bus(1'b0, GPIO_OE,     4'b0000, '0, 32'h0000_00FF);
        bus(1'b0, GPIO_IRQ_EN, 4'b0000, '0, 32'h0000_0000);
    endtask

    task automatic test_set_clr_tgl();
        logic [7:0] exp_o [4] = '{8'hA5, 8'hAF, 8'h2F, 8'h2C};
        logic [3:0] regs  [4] = '{GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL};
        logic [7:0] dat   [4] = '{8'hA5, 8'h0F, 8'h80, 8'h03};
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, regs[i], 4'b1111, {24'hFFFF_FF, dat[i]}, '0);
            n_checks++;
            if (gpio_o !== exp_o[i]) $display("FAIL alias_%0d gpio_o got=%h want=%h", i, gpio_o, exp_o[i]);
            else n_pass++;
        end
        bus(1'b0, GPIO_SET, 4'b0000, '0, 32'h0);
        bus(1'b0, GPIO_CLR, 4'b0000, '0, 32'h0);
        bus(1'b0, GPIO_TGL, 4'b0000, '0, 32'h0);
        bus(1'b0, 4'd12,    4'b1111, 32'hFFFF_FFFF, '0);
        bus(1'b0, 4'd12,    4'b0000, '0, 32'h0);
        bus(1'b0, GPIO_OUT, 4'b0000, '0, 32'h0000_002C);
    endtask

    task automatic test_byte_lanes();
        bus(1'b1, GPIO_OUT, 4'b0010, 32'hFFFF_FFFF, '0);
        n_checks++;
        if (gpio_o12 !== 12'hF00) $display("FAIL lane_w12 gpio_o got=%h want=f00", gpio_o12);
        else n_pass++;
        bus(1'b1, GPIO_OUT, 4'b0000, '0, 32'h0000_0F00);
        bus(1'b0, GPIO_OUT, 4'b1110, 32'hFFFF_FFFF, '0);
        n_checks++;
        if (gpio_o !== 8'h2C) $display("FAIL lane_w8_upper gpio_o got=%h want=2c", gpio_o);
        else n_pass++;
    endtask

    task automatic test_input();
        @(negedge clk);
        gpio_i = 8'h3C;
        repeat (2) @(posedge clk);
        bus(1'b0, GPIO_IN, 4'b0000, '0, 32'h0000_003C);
        bus(1'b0, GPIO_STATUS, 4'b0000, '0, 32'h0);
        @(negedge clk);
        gpio_i = 8'h00;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_edge_irq();
        bus(1'b0, GPIO_RISE_EN, 4'b0001, 32'h01, '0);
        bus(1'b0, GPIO_IRQ_EN,  4'b0001, 32'h01, '0);
        @(negedge clk);
        gpio_i[0] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (irq !== (e == 2)) $display("FAIL irq_latency edge=%0d got=%b want=%b", e, irq, (e == 2));
            else n_pass++;
        end
        bus(1'b0, GPIO_STATUS, 4'b0000, '0, 32'h0000_0001);
        bus(1'b0, GPIO_STATUS, 4'b0001, 32'h01, '0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_w1c got=%b want=0", irq);
        else n_pass++;
        bus(1'b0, GPIO_STATUS, 4'b0000, '0, 32'h0);
    endtask

    task automatic test_w1c_race();
        bus(1'b0, GPIO_FALL_EN, 4'b0001, 32'h04, '0);
        @(negedge clk);
        gpio_i[2] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        gpio_i[2] = 1'b0;
        repeat (2) @(posedge clk);
        bus(1'b0, GPIO_STATUS, 4'b0001, 32'h04, '0);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL race_irq_masked got=%b want=0", irq);
        else n_pass++;
        bus(1'b0, GPIO_STATUS, 4'b0000, '0, 32'h0000_0004);
        bus(1'b0, GPIO_STATUS, 4'b0001, 32'h04, '0);
        bus(1'b0, GPIO_STATUS, 4'b0000, '0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic want_rdy;
        logic [31:0] want;
        @(negedge clk);
        sel = 1'b1; addr = GPIO_OE; wstrb = 4'b0000; wdata = '0;
        exp_q.push_back(32'h0000_00FF);
        exp_q.push_back(32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            want_rdy = (i % 2 == 0);
            n_checks++;
            if (ready !== want_rdy) $display("FAIL b2b_ready cyc=%0d got=%b want=%b", i, ready, want_rdy);
            else n_pass++;
            if (ready === 1'b1) begin
                want = exp_q.pop_front();
                n_checks++;
                if (rdata !== want) $display("FAIL b2b_rdata cyc=%0d got=%h want=%h", i, rdata, want);
                else n_pass++;
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] want;
        bus(1'b0, GPIO_OUT, 4'b0001, 32'h5A, '0);
        @(negedge clk);
        sel = 1'b1; addr = GPIO_OE; wstrb = 4'b0000;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL midrst_pre_ready got=%b want=1", ready);
        else n_pass++;
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || rdata !== 32'h0 || gpio_o !== 8'h00 || gpio_oe !== 8'hFF)
            $display("FAIL midrst_async got rdy=%b rd=%h o=%h oe=%h want 0/0/00/ff",
                     ready, rdata, gpio_o, gpio_oe);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.push_back(32'h0000_00FF);
        @(posedge clk); #1;
        sel = 1'b0;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL midrst_reissue_ready got=%b want=1", ready);
        else n_pass++;
        want = exp_q.pop_front();
        n_checks++;
        if (rdata !== want) $display("FAIL midrst_reissue_rdata got=%h want=%h", rdata, want);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL midrst_ready_low got=%b want=0", ready);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_set_clr_tgl();
        test_byte_lanes();
        test_input();
        test_edge_irq();
        test_w1c_race();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
